uart_word_tx: RTL
=================

// Module: uart_word_tx
// PURPOSE
//  Word-to-byte streamer for the 27MHz/3Mbps UART link. On a start pulse it reads word_count 32-bit words
//  from a combinational-read memory, beginning at base_addr, and sends each word as 4 bytes, LSB byte first.
//  Bytes go to the byte-level UART transmitter through its send_trig/send_data/tx_bsy handshake.
//  Counterpart of the host-side receiver, which rebuilds words from bytes LSB first.
// PARAMETERS
//  ADDR_WIDTH   5   memory address width; addresses wrap modulo 2**ADDR_WIDTH
//  DATA_WIDTH   32  word width; fixed at 32 (4 bytes per word)
//  GAP_CYCLES   0   idle clocks inserted between the tx_bsy fall and the next send_trig (0..255)
// PORTS
//  clk            in   1             system clock
//  rst            in   1             synchronous reset, active-high
//  start          in   1             one-cycle request; sampled only in IDLE
//  base_addr      in   ADDR_WIDTH    first word address; captured at start
//  word_count     in   ADDR_WIDTH+1  number of words to send (0..2**ADDR_WIDTH); captured at start
//  busy           out  1             high from the cycle after start is accepted until done
//  done           out  1             one-cycle pulse when the transfer completes
//  mem_addr       out  ADDR_WIDTH    registered memory address
//  mem_rdata      in   DATA_WIDTH    combinational read data for mem_addr
//  tx_send_trig   out  1             one-cycle byte-send strobe to the UART tx
//  tx_send_data   out  8             byte to send; held stable from the trig until tx_bsy falls
//  tx_bsy         in   1             UART tx busy; rises the cycle after an accepted trig
// BEHAVIOUR
//  - Reset values: busy=0, done=0, tx_send_trig=0, tx_send_data=0, mem_addr=0. FSM goes to IDLE; counters clear.
//  - FSM: IDLE -> LOAD -> TRIG -> WAIT_HI -> WAIT_LO -> GAP -> (TRIG | LOAD | FIN) ; FIN -> IDLE.
//  - IDLE: when start=1, capture base_addr and word_count, set mem_addr<=base_addr, go to LOAD.
//    If word_count=0, go straight to FIN instead (done pulses one cycle later; no trig issued).
//  - LOAD: word_reg<=mem_rdata; byte_idx<=0; go to TRIG.
//  - TRIG: issue a trig only when tx_bsy=0. Set tx_send_trig=1 for exactly one cycle and
//    tx_send_data=word_reg[8*byte_idx+:8]. Otherwise hold in TRIG.
//  - WAIT_HI: wait for tx_bsy=1. WAIT_LO: wait for tx_bsy=0. Then GAP counts GAP_CYCLES clocks (zero means skip).
//  - After GAP:
//    - byte_idx<3: byte_idx++ and go to TRIG.
//    - Otherwise, if words remain: mem_addr<=mem_addr+1 (wraps) and go to LOAD.
//    - Otherwise go to FIN.
//  - FIN: done=1 for one cycle; busy=0 in the same cycle the FSM returns to IDLE.
//  - Latency: start sampled in cycle N gives the first tx_send_trig in cycle N+2.
//  - start while busy is ignored; there is no queueing.
//  - rst mid-transfer aborts immediately, with no partial done. tx_send_trig is forced low the same cycle.
//  - word_count=2**ADDR_WIDTH with any base_addr sends every location once, wrapping past the top address.
// CONFIGURATION
//  UART_WORD_TX_CHKSUM_EN defined:
//    - Keep a 32-bit running sum (mod 2**32) of every word loaded.
//    - After the last word, send the sum as 4 extra bytes, LSB first, through the same TRIG/WAIT path,
//      then go to FIN. The sum clears at start.
//    - word_count=0 still sends the checksum (0x00000000).
//  UART_WORD_TX_CHKSUM_EN undefined: no sum register; FIN follows the last data byte.
// STRUCTURE
//  - Package uart_word_tx_pkg: FSM state enum, BYTES_PER_WORD=4, GAP counter width.
//  - One sub-module, uart_word_tx_ser: holds word_reg and byte_idx, and presents the current byte
//    and a last-byte flag. The top level holds the FSM, address/word counters and the checksum.
// TESTING
//  - Bench model of the UART tx: tx_bsy rises 1 cycle after trig and stays high 91 cycles.
//  - T1: mem[0]=0x11223344, base=0, count=1 -> trig bytes 44,33,22,11; done one cycle after the 4th tx_bsy fall.
//  - T2: base=30, count=4, mem[30,31,0,1]=A0A1A2A3,B0B1B2B3,C0C1C2C3,D0D1D2D3 -> mem_addr goes 30,31,0,1;
//    16 bytes starting A3,A2,A1,A0.
//  - T3: count=0 -> done at N+2; zero trigs.
//    With CHKSUM_EN: 4 trigs of 0x00, then done.
//  - T4: hold tx_bsy=1 externally for 200 cycles at start -> first trig waits until tx_bsy=0; no lost byte.
//  - T5: rst after the 5th trig of a 3-word run -> outputs at reset values next cycle.
//    A new start then sends from its new base correctly.
//  - T6 (CHKSUM_EN): words 0xFFFFFFFF,0x00000002 -> trailing bytes 01,00,00,00.
//    Also re-pulse start while busy -> ignored.

Source files
------------

// File: rtl/uart_word_tx_pkg.sv
// Shared types and constants for the word-to-byte UART streamer.
package uart_word_tx_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int GAP_W          = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_FIN
    } state_e;

    // Byte lane i of a word, lane 0 being the least significant byte.
    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] w,
                                            input logic [BYTE_IDX_W-1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Handshake bundle of the streamer: control, memory read port and UART byte port.
interface uart_word_tx_if
    import uart_word_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = WORD_W
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  tx_send_trig;
    logic [7:0]            tx_send_data;
    logic                  tx_bsy;

    // Requester side: drives the request, serves memory reads, models the UART.
    modport master (
        output start, base_addr, word_count, mem_rdata, tx_bsy,
        input  busy, done, mem_addr, tx_send_trig, tx_send_data
    );

    // Streamer side.
    modport slave (
        input  start, base_addr, word_count, mem_rdata, tx_bsy,
        output busy, done, mem_addr, tx_send_trig, tx_send_data
    );
endinterface

// File: rtl/uart_word_tx_ser.sv
// Word serializer: holds the word being sent and the current byte lane.
module uart_word_tx_ser
    import uart_word_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [7:0]        cur_byte_o,
    output logic [7:0]        nxt_byte_o,
    output logic              last_o
);
    logic [WORD_W-1:0]     word_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    // Load restarts at lane 0; advance steps to the next more significant lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
        end else if (adv_i) begin
            idx_q  <= idx_q + BYTE_IDX_W'(1);
        end
    end

    // The next lane is offered so the FSM can register it on the same edge it advances.
    assign cur_byte_o = get_byte(word_q, idx_q);
    assign nxt_byte_o = get_byte(word_q, idx_q + BYTE_IDX_W'(1));
    assign last_o     = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-byte streamer: reads words from memory and feeds them LSB byte first
// to a byte UART transmitter. Optional trailing checksum: UART_WORD_TX_CHKSUM_EN.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave bus
);
    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  trig_q;
    logic [7:0]            data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   left_q;
    logic [GAP_W-1:0]      gap_q;
`ifdef UART_WORD_TX_CHKSUM_EN
    logic [WORD_W-1:0]     sum_q;
    logic                  chk_q;   // serializer currently holds the checksum word
`endif

    logic [WORD_W-1:0]     load_word;
    logic                  byte_done;
    logic                  ser_load;
    logic                  ser_adv;
    logic                  ser_last;
    logic [7:0]            cur_byte;
    logic [7:0]            nxt_byte;

    // Word source for LOAD, and the "byte finished, gap elapsed" decision point.
    always_comb begin
        load_word = bus.mem_rdata;
`ifdef UART_WORD_TX_CHKSUM_EN
        if (chk_q) load_word = sum_q;
`endif
        byte_done = ((state_q == S_WAIT_LO) && !bus.tx_bsy && (GAP_CYCLES == 0)) ||
                    ((state_q == S_GAP) && (gap_q == '0));
        ser_load  = (state_q == S_LOAD);
        ser_adv   = byte_done && !ser_last;
    end

    uart_word_tx_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .adv_i      (ser_adv),
        .word_i     (load_word),
        .cur_byte_o (cur_byte),
        .nxt_byte_o (nxt_byte),
        .last_o     (ser_last)
    );

    // Main FSM. A trig is launched on the edge entering TRIG whenever the UART is
    // already idle, so the first byte leaves two cycles after start; otherwise TRIG
    // retries each cycle until tx_bsy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            gap_q   <= '0;
`ifdef UART_WORD_TX_CHKSUM_EN
            sum_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            trig_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q <= bus.base_addr;
                        left_q <= bus.word_count;
                        busy_q <= 1'b1;
`ifdef UART_WORD_TX_CHKSUM_EN
                        sum_q   <= '0;
                        chk_q   <= (bus.word_count == '0);
                        state_q <= S_LOAD;
`else
                        state_q <= (bus.word_count == '0) ? S_FIN : S_LOAD;
`endif
                    end
                end
                S_LOAD: begin
`ifdef UART_WORD_TX_CHKSUM_EN
                    if (!chk_q) begin
                        sum_q  <= sum_q + bus.mem_rdata;
                        left_q <= left_q - (ADDR_WIDTH+1)'(1);
                    end
`else
                    left_q <= left_q - (ADDR_WIDTH+1)'(1);
`endif
                    trig_q  <= !bus.tx_bsy;
                    data_q  <= load_word[7:0];
                    state_q <= S_TRIG;
                end
                S_TRIG: begin
                    if (trig_q) begin
                        state_q <= S_WAIT_HI;
                    end else if (!bus.tx_bsy) begin
                        trig_q <= 1'b1;
                        data_q <= cur_byte;
                    end
                end
                S_WAIT_HI: begin
                    if (bus.tx_bsy) state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!bus.tx_bsy && (GAP_CYCLES != 0)) begin
                        gap_q   <= GAP_W'(GAP_CYCLES - 1);
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Byte complete: next lane, next word, checksum word, or finish.
            if (byte_done) begin
                if (!ser_last) begin
                    state_q <= S_TRIG;
                    trig_q  <= !bus.tx_bsy;
                    data_q  <= nxt_byte;
                end else if (left_q != '0) begin
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    state_q <= S_LOAD;
                end
`ifdef UART_WORD_TX_CHKSUM_EN
                else if (!chk_q) begin
                    chk_q   <= 1'b1;
                    state_q <= S_LOAD;
                end
`endif
                else begin
                    state_q <= S_FIN;
                end
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mem_addr     = addr_q;
    assign bus.tx_send_trig = trig_q;
    assign bus.tx_send_data = data_q;

endmodule
